dense_instr_unpack: RTL and testbench
=====================================

# dense_instr_unpack

Upstream feeder of the dense-layer decode register stage. Accepts a stream of data_size-bit instruction words over a valid/ready handshake and assembles one dense-layer instruction from them: layer types, flags, learning rate, backprop control, and optional w/x/label vectors. On completion it presents the fields in parallel and pulses out_valid for one cycle. The decode register stage downstream registers the fields and has no backpressure.

## Interface
- size, 3, vector elements per w/x/label
- data_size, 16, bits per stream word and per vector element; must be ≥ act_type_size+dense_type_size+cost_type_size and ≥ learning_rate_size
- act_type_size, 4, activation code width
- dense_type_size, 4, dense code width
- cost_type_size, 8, cost code width
- learning_rate_size, 16, learning rate width
- backprop_controll_size, 66, backprop control width (1+1+32+32)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort of a partial instruction
- in_data  in  data_size  stream word
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid && in_ready
- act_type_out, dense_type_out, cost_type_out  out  respective sizes  header fields
- learning_rate_out  out  learning_rate_size
- backprop_controll_out  out  backprop_controll_size
- w_out, x_out, label_out  out  data_size*size each  element i at bits [i*data_size +: data_size]
- load_w_out  out  1  qualified by out_valid
- out_valid  out  1  one-cycle pulse, all fields valid

## Operation
- Word order: HDR, FLAGS, LR, BP×BP_WORDS, then W×size if flags[0], X×size if flags[1], LABEL×size if flags[2]. BP_WORDS = ceil(backprop_controll_size/data_size), which is 5 at the defaults.
- HDR word: act_type = [3:0], dense_type = [7:4], cost_type = [15:8]. These are the default offsets; in general each field sits above the previous one.
- FLAGS word: [0] load_w, [1] x_present, [2] label_present. Other bits are ignored.
- LR word: learning_rate = low learning_rate_size bits.
- BP words: LSB first. Word k fills bits [k*data_size +: data_size]. Bits beyond backprop_controll_size in the last word are dropped.
- Vectors: the first word received is element 0.
- FSM states and transitions:
  - HDR→FLAGS→LR→BP on each accepted word.
  - BP exits after BP_WORDS words to W, X, LABEL or EMIT, skipping sections whose flag is 0.
  - W, X and LABEL each take size words, then go to the next enabled section or to EMIT.
  - EMIT→HDR unconditionally.
- A single element counter is shared by BP, W, X and LABEL and cleared on each section entry.
- Field registers update only as their words arrive. A vector whose flag is 0 keeps its previous value.
- load_w_out equals the flags[0] of the instruction being emitted. It is 0 outside EMIT.
- flush: state→HDR and counter→0. No out_valid. Output fields are not rolled back; partially written fields may differ and are don't-care until the next out_valid. flush beats in_valid in the same cycle, and that word is discarded.
- rst: all outputs and field registers 0, out_valid 0, load_w_out 0, state HDR. This takes effect immediately and asynchronously, including mid-instruction.

## Timing
- in_ready = 1 in every state except EMIT. It is a combinational decode of state and is 1 right after reset release.
- Throughput is one word per cycle. Gaps in in_valid simply stall the FSM.
- Latency: out_valid is asserted the cycle after the last word is accepted, with all fields stable in that cycle. The next HDR word can be accepted the cycle after EMIT.
- Minimum instruction is 3+BP_WORDS = 8 words, giving one emit per 9 cycles. Maximum is 8+3*size = 17 words, giving one emit per 18 cycles.
- A word presented during EMIT is held by the source (in_ready = 0) and is accepted in HDR as the next header.

## Structure
- Shared package dense_pkg holds:
  - state enum: ST_HDR, ST_FLAGS, ST_LR, ST_BP, ST_W, ST_X, ST_LABEL, ST_EMIT
  - flag bit indices: FLAG_LOAD_W = 0, FLAG_X = 1, FLAG_LABEL = 2
  - a function computing BP_WORDS
- Single module, no sub-modules. Its outputs connect one-to-one to the decode register stage inputs.

## Test plan
- Full instruction, in_valid held high. Words: 0x2513, 0x0007, 0x0100, BP 0x1111/0x2222/0x3333/0x4444/0xFFFF, W 0xA/0xB/0xC, X 1/2/3, LABEL 4/5/6. Required response:
  - act = 3, dense = 1, cost = 0x25, lr = 0x0100
  - bp = {2'b11, 0x4444, 0x3333, 0x2222, 0x1111}
  - w_out = 0x000C000B000A, load_w_out = 1
  - out_valid for exactly one cycle, the cycle after the 17th accept
- Then flags = 0x0000. out_valid follows the 8th word. w/x/label_out keep the prior values and load_w_out = 0.
- Repeat test 1 with in_valid toggling every cycle. Fields are identical, out_valid occurs once, and in_ready is low only in the EMIT cycle.
- Assert flush after the 2nd W word, then send a fresh flags = 0x0002 instruction. There is no out_valid for the aborted instruction. The next emit has x_out updated and w_out unchanged from before flush.
- Assert rst asynchronously mid-BP. All outputs read 0 before the next clock edge. The first word after release is decoded as HDR.
- Hold in_valid high across EMIT with next word 0x0042. It is not accepted during EMIT, and the next emit reports act = 2, dense = 4.

Source files
------------

// File: rtl/dense_instr_unpack_pkg.sv
// dense_pkg: shared states, flag indices and word-count helper for the dense instruction unpacker.
package dense_pkg;
  typedef enum logic [2:0] {
    ST_HDR, ST_FLAGS, ST_LR, ST_BP, ST_W, ST_X, ST_LABEL, ST_EMIT
  } state_t;
  localparam int FLAG_LOAD_W = 0;
  localparam int FLAG_X = 1;
  localparam int FLAG_LABEL = 2;
  function automatic int bp_words(input int bits, input int word_bits);
    return (bits + word_bits - 1) / word_bits;
  endfunction
endpackage

// File: rtl/dense_instr_unpack.sv
// dense_instr_unpack: assembles one dense-layer instruction from a stream of words and pulses out_valid.
module dense_instr_unpack
  import dense_pkg::*;
#(
  parameter int size = 3,
  parameter int data_size = 16,
  parameter int act_type_size = 4,
  parameter int dense_type_size = 4,
  parameter int cost_type_size = 8,
  parameter int learning_rate_size = 16,
  parameter int backprop_controll_size = 66
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [data_size-1:0]              in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [act_type_size-1:0]          act_type_out,
  output logic [dense_type_size-1:0]        dense_type_out,
  output logic [cost_type_size-1:0]         cost_type_out,
  output logic [learning_rate_size-1:0]     learning_rate_out,
  output logic [backprop_controll_size-1:0] backprop_controll_out,
  output logic [data_size*size-1:0]         w_out,
  output logic [data_size*size-1:0]         x_out,
  output logic [data_size*size-1:0]         label_out,
  output logic                              load_w_out,
  output logic                              out_valid
);
  localparam int BPW = bp_words(backprop_controll_size, data_size);
  localparam int CNT_MAX = BPW > size ? BPW : size;
  localparam int CW = CNT_MAX > 1 ? $clog2(CNT_MAX) : 1;
  state_t state, nxt, after_w, after_x, after_bp;
  logic [CW-1:0] cnt;
  logic [2:0] flags;
  logic acc, last;
  logic [backprop_controll_size-1:0] bp_n;
  assign in_ready = state != ST_EMIT;
  assign out_valid = state == ST_EMIT;
  assign load_w_out = out_valid && flags[FLAG_LOAD_W];
  assign acc = in_valid && in_ready && !flush;
  assign last = cnt == CW'((state == ST_BP ? BPW : size) - 1);
  assign after_x = flags[FLAG_LABEL] ? ST_LABEL : ST_EMIT;
  assign after_w = flags[FLAG_X] ? ST_X : after_x;
  assign after_bp = flags[FLAG_LOAD_W] ? ST_W : after_w;
  always_comb begin
    nxt = state;
    case (state)
      ST_HDR:   nxt = acc ? ST_FLAGS : state;
      ST_FLAGS: nxt = acc ? ST_LR : state;
      ST_LR:    nxt = acc ? ST_BP : state;
      ST_BP:    nxt = acc && last ? after_bp : state;
      ST_W:     nxt = acc && last ? after_w : state;
      ST_X:     nxt = acc && last ? after_x : state;
      ST_LABEL: nxt = acc && last ? ST_EMIT : state;
      default:  nxt = ST_HDR;
    endcase
    if (flush) nxt = ST_HDR;
  end
  // bits of the last BP word beyond the field width are simply never addressed
  always_comb begin
    bp_n = backprop_controll_out;
    for (int b = 0; b < backprop_controll_size; b++)
      if (cnt == CW'(b / data_size)) bp_n[b] = in_data[b % data_size];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_HDR;
      cnt <= '0;
      flags <= '0;
      act_type_out <= '0;
      dense_type_out <= '0;
      cost_type_out <= '0;
      learning_rate_out <= '0;
      backprop_controll_out <= '0;
      w_out <= '0;
      x_out <= '0;
      label_out <= '0;
    end else begin
      state <= nxt;
      cnt <= (flush || nxt != state) ? '0 : acc ? cnt + CW'(1) : cnt;
      if (acc)
        case (state)
          ST_HDR: begin
            act_type_out <= in_data[act_type_size-1:0];
            dense_type_out <= in_data[act_type_size +: dense_type_size];
            cost_type_out <= in_data[act_type_size+dense_type_size +: cost_type_size];
          end
          ST_FLAGS: flags <= in_data[2:0];
          ST_LR:    learning_rate_out <= in_data[learning_rate_size-1:0];
          ST_BP:    backprop_controll_out <= bp_n;
          ST_W:     w_out[cnt*data_size +: data_size] <= in_data;
          ST_X:     x_out[cnt*data_size +: data_size] <= in_data;
          ST_LABEL: label_out[cnt*data_size +: data_size] <= in_data;
          default:  ;
        endcase
    end
  end
endmodule

// File: tb/tb_dense_instr_unpack.sv
// tb_dense_instr_unpack: directed and random instructions checked against a word-list parsing model.
module tb_dense_instr_unpack;
  typedef logic [15:0] wq_t[$];
  typedef struct {
    logic [3:0] act;
    logic [3:0] dense;
    logic [7:0] cost;
    logic [15:0] lr;
    logic [65:0] bp;
    logic [47:0] w, x, label;
    logic load_w;
  } rec_t;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0;
  logic [15:0] in_data = '0;
  logic in_ready, load_w_out, out_valid;
  logic [3:0] act_type_out, dense_type_out;
  logic [7:0] cost_type_out;
  logic [15:0] learning_rate_out;
  logic [65:0] backprop_controll_out;
  logic [47:0] w_out, x_out, label_out;
  int checks = 0, errors = 0;
  rec_t exp_q[$];
  logic [15:0] m_w[3], m_x[3], m_l[3];
  dense_instr_unpack dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .act_type_out(act_type_out), .dense_type_out(dense_type_out),
    .cost_type_out(cost_type_out), .learning_rate_out(learning_rate_out),
    .backprop_controll_out(backprop_controll_out), .w_out(w_out), .x_out(x_out),
    .label_out(label_out), .load_w_out(load_w_out), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic void model_reset();
    for (int e = 0; e < 3; e++) begin m_w[e] = 0; m_x[e] = 0; m_l[e] = 0; end
  endfunction
  // parse complete instructions from a word list by the stream format rules
  function automatic void model(input wq_t w);
    int p = 0;
    rec_t r;
    logic [79:0] acc;
    logic [15:0] f;
    while (p + 8 <= w.size()) begin
      r.act = w[p][3:0];
      r.dense = w[p][7:4];
      r.cost = w[p][15:8];
      f = w[p+1];
      r.load_w = f[0];
      r.lr = w[p+2];
      acc = '0;
      for (int k = 0; k < 5; k++) acc = acc | (80'(w[p+3+k]) << (16 * k));
      r.bp = acc[65:0];
      p += 8;
      if (f[0]) for (int e = 0; e < 3; e++) m_w[e] = w[p++];
      if (f[1]) for (int e = 0; e < 3; e++) m_x[e] = w[p++];
      if (f[2]) for (int e = 0; e < 3; e++) m_l[e] = w[p++];
      r.w = {m_w[2], m_w[1], m_w[0]};
      r.x = {m_x[2], m_x[1], m_x[0]};
      r.label = {m_l[2], m_l[1], m_l[0]};
      exp_q.push_back(r);
    end
  endfunction
  function automatic wq_t rand_instr();
    wq_t q;
    logic [15:0] f;
    int n;
    f = 16'($urandom);
    q.push_back(16'($urandom));
    q.push_back(f);
    n = 6 + 3 * (int'(f[0]) + int'(f[1]) + int'(f[2]));
    for (int i = 0; i < n; i++) q.push_back(16'($urandom));
    return q;
  endfunction
  task automatic check_zero(input string tag);
    chk({tag, " act"}, 128'(act_type_out), 0);
    chk({tag, " dense"}, 128'(dense_type_out), 0);
    chk({tag, " cost"}, 128'(cost_type_out), 0);
    chk({tag, " lr"}, 128'(learning_rate_out), 0);
    chk({tag, " bp"}, 128'(backprop_controll_out), 0);
    chk({tag, " w"}, 128'(w_out), 0);
    chk({tag, " x"}, 128'(x_out), 0);
    chk({tag, " label"}, 128'(label_out), 0);
    chk({tag, " out_valid"}, 128'(out_valid), 0);
    chk({tag, " load_w"}, 128'(load_w_out), 0);
  endtask
  // drive a word list; each out_valid is compared with the next queued model record
  task automatic send(input string tag, input wq_t w, input bit toggle);
    int i = 0, cyc = 0, last_acc = -10;
    bit prev_acc = 0, v;
    rec_t r;
    while (cyc < 400 && (i < w.size() || cyc <= last_acc + 1)) begin
      @(negedge clk);
      if (out_valid) begin
        chk({tag, " emit_expected"}, 128'(exp_q.size() != 0), 1);
        chk({tag, " emit_latency"}, 128'(prev_acc), 1);
        chk({tag, " in_ready_emit"}, 128'(in_ready), 0);
        if (exp_q.size() != 0) begin
          r = exp_q.pop_front();
          chk({tag, " act"}, 128'(act_type_out), 128'(r.act));
          chk({tag, " dense"}, 128'(dense_type_out), 128'(r.dense));
          chk({tag, " cost"}, 128'(cost_type_out), 128'(r.cost));
          chk({tag, " lr"}, 128'(learning_rate_out), 128'(r.lr));
          chk({tag, " bp"}, 128'(backprop_controll_out), 128'(r.bp));
          chk({tag, " w"}, 128'(w_out), 128'(r.w));
          chk({tag, " x"}, 128'(x_out), 128'(r.x));
          chk({tag, " label"}, 128'(label_out), 128'(r.label));
          chk({tag, " load_w"}, 128'(load_w_out), 128'(r.load_w));
        end
      end else begin
        chk({tag, " in_ready"}, 128'(in_ready), 1);
        chk({tag, " load_w_idle"}, 128'(load_w_out), 0);
      end
      v = i < w.size() && (!toggle || cyc % 2 == 0);
      in_valid = v;
      in_data = v ? w[i] : 16'($urandom);
      prev_acc = v && in_ready;
      if (prev_acc) begin i++; last_acc = cyc; end
      cyc++;
    end
    in_valid = 0;
    chk({tag, " all_words_accepted"}, 128'(i), 128'(w.size()));
    chk({tag, " all_emits_seen"}, 128'(exp_q.size()), 0);
  endtask
  task automatic feed_raw(input string tag, input wq_t w);
    foreach (w[i]) begin
      @(negedge clk);
      chk({tag, " no_emit"}, 128'(out_valid), 0);
      in_valid = 1;
      in_data = w[i];
    end
  endtask
  initial begin
    wq_t t1, t2, t, a;
    t1 = '{16'h2513, 16'h0007, 16'h0100, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hFFFF,
           16'h000A, 16'h000B, 16'h000C, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
    t2 = '{16'h7F39, 16'h0000, 16'h1234, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0002};
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 0;
    @(negedge clk);
    chk("in_ready_after_reset", 128'(in_ready), 1);
    model(t1);
    send("t1", t1, 0);
    chk("t1 act_const", 128'(act_type_out), 128'h3);
    chk("t1 dense_const", 128'(dense_type_out), 128'h1);
    chk("t1 cost_const", 128'(cost_type_out), 128'h25);
    chk("t1 lr_const", 128'(learning_rate_out), 128'h0100);
    chk("t1 bp_const", 128'(backprop_controll_out), 128'h3_4444_3333_2222_1111);
    chk("t1 w_const", 128'(w_out), 128'h000C000B000A);
    model(t2);
    send("t2", t2, 0);
    chk("t2 x_kept", 128'(x_out), 128'h000300020001);
    chk("t2 label_kept", 128'(label_out), 128'h000600050004);
    model(t1);
    send("t3_toggle", t1, 1);
    // abort after the second W word; the aborted words repeat the current w so w_out stays put
    feed_raw("flush", '{16'h1111, 16'h0001, 16'h2222, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h000A, 16'h000B});
    @(negedge clk);
    chk("flush no_emit", 128'(out_valid), 0);
    flush = 1;
    in_valid = 1;
    in_data = 16'hDEAD;
    @(negedge clk);
    flush = 0;
    in_valid = 0;
    chk("flush no_emit_after", 128'(out_valid), 0);
    t = '{16'h0521, 16'h0002, 16'h0033, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h0007, 16'h0008, 16'h0009};
    model(t);
    send("post_flush", t, 0);
    chk("post_flush w_unchanged", 128'(w_out), 128'h000C000B000A);
    chk("post_flush x_updated", 128'(x_out), 128'h000900080007);
    feed_raw("rst_mid", '{16'h2513, 16'h0007, 16'h0100, 16'h1111, 16'h2222});
    #2 rst = 1;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst = 0;
    in_valid = 0;
    model_reset();
    t = rand_instr();
    model(t);
    send("after_rst", t, 0);
    a = rand_instr();
    t = '{16'h0042, 16'h0000, 16'h0001, 16'h9, 16'h8, 16'h7, 16'h6, 16'h5};
    a = {a, t};
    model(a);
    send("hold_emit", a, 0);
    chk("hold_emit act", 128'(act_type_out), 128'h2);
    chk("hold_emit dense", 128'(dense_type_out), 128'h4);
    for (int n = 0; n < 12; n++) begin
      t = rand_instr();
      if (n % 3 == 0) t = {t, rand_instr()};
      model(t);
      send("random", t, 1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
